// File: rtl/trigger_bank_ctrl.sv
// trigger_bank_ctrl: allocates, programs and reports a bank of external trigger slots
module trigger_bank_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int PRICE_WIDTH = 8,
    parameter int ID_WIDTH = 4,
    localparam int SLOT_W = $clog2(NUM_SLOTS)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm_valid,
    output logic                   arm_ready,
    input  logic                   arm_side,
    input  logic                   arm_direction,
    input  logic [PRICE_WIDTH-1:0] arm_price,
    input  logic [ID_WIDTH-1:0]    arm_id,
    input  logic                   cancel_valid,
    input  logic [ID_WIDTH-1:0]    cancel_id,
    output logic [NUM_SLOTS-1:0]   trig_write_enable,
    output logic                   trig_side,
    output logic                   trig_direction,
    output logic [PRICE_WIDTH-1:0] trig_price,
    input  logic [NUM_SLOTS-1:0]   trig_satisfied,
    output logic                   fire_valid,
    input  logic                   fire_ready,
    output logic [ID_WIDTH-1:0]    fire_id,
    output logic [SLOT_W-1:0]      fire_slot,
    output logic [NUM_SLOTS-1:0]   slots_busy
);
    typedef enum logic [2:0] {FREE, WRITE, SETTLE, ARMED, PENDING} slot_state_t;

    slot_state_t          state_q [NUM_SLOTS];
    slot_state_t          state_d [NUM_SLOTS];
    logic [ID_WIDTH-1:0]  id_q [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] cancel_hit;
    logic [NUM_SLOTS-1:0] cand;
    logic [SLOT_W-1:0]    rr_ptr;
    logic [SLOT_W-1:0]    alloc;
    logic [SLOT_W-1:0]    after_fire;
    logic [SLOT_W-1:0]    start;
    logic [SLOT_W-1:0]    sel;
    logic                 accept;
    logic                 handshake;
    logic                 found;
    int                   idx;

    // Occupancy, cancel matching (presented slot exempt) and lowest-free allocation on pre-cancel state
    always_comb begin
        alloc = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            slots_busy[i] = state_q[i] != FREE;
            cancel_hit[i] = cancel_valid && slots_busy[i] && id_q[i] == cancel_id &&
                            !(fire_valid && fire_slot == SLOT_W'(i));
            alloc = slots_busy[i] ? alloc : SLOT_W'(i);
        end
        arm_ready = !(&slots_busy);
        accept = arm_valid && arm_ready;
        handshake = fire_valid && fire_ready;
        after_fire = (fire_slot == SLOT_W'(NUM_SLOTS - 1)) ? '0 : fire_slot + SLOT_W'(1);
        start = handshake ? after_fire : rr_ptr;
    end

    // Round-robin pick of the next PENDING slot, skipping slots that leave this cycle
    always_comb begin
        found = 1'b0;
        sel = '0;
        idx = 0;
        for (int i = 0; i < NUM_SLOTS; i++)
            cand[i] = state_q[i] == PENDING && !cancel_hit[i] && !(handshake && fire_slot == SLOT_W'(i));
        for (int k = 0; k < NUM_SLOTS; k++) begin
            idx = int'(start) + k;
            idx = idx >= NUM_SLOTS ? idx - NUM_SLOTS : idx;
            if (!found && cand[SLOT_W'(idx)]) begin
                found = 1'b1;
                sel = SLOT_W'(idx);
            end
        end
    end

    // Per-slot lifecycle; cancel and report acceptance both return a slot to FREE
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                FREE:    state_d[i] = (accept && alloc == SLOT_W'(i)) ? WRITE : FREE;
                WRITE:   state_d[i] = SETTLE;
                SETTLE:  state_d[i] = ARMED;
                ARMED:   state_d[i] = trig_satisfied[i] ? PENDING : ARMED;
                default: state_d[i] = state_q[i];
            endcase
            if (cancel_hit[i] || (handshake && fire_slot == SLOT_W'(i)))
                state_d[i] = FREE;
        end
    end

    // Slot state register and stored order ids
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_q[i] <= FREE;
                id_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++)
                state_q[i] <= state_d[i];
            if (accept)
                id_q[alloc] <= arm_id;
        end
    end

    // Shared write bus: one-cycle strobe, data held until the next accepted arm
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            trig_write_enable <= '0;
            trig_side <= 1'b0;
            trig_direction <= 1'b0;
            trig_price <= '0;
        end else begin
            trig_write_enable <= accept ? NUM_SLOTS'(1) << alloc : '0;
            if (accept) begin
                trig_side <= arm_side;
                trig_direction <= arm_direction;
                trig_price <= arm_price;
            end
        end
    end

    // Registered fire report and round-robin pointer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fire_valid <= 1'b0;
            fire_id <= '0;
            fire_slot <= '0;
            rr_ptr <= '0;
        end else begin
            if (handshake)
                rr_ptr <= after_fire;
            if (!fire_valid || handshake) begin
                fire_valid <= found;
                if (found) begin
                    fire_id <= id_q[sel];
                    fire_slot <= sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_trigger_bank_ctrl.sv
// tb_trigger_bank_ctrl: table-driven directed check of trigger_bank_ctrl
module tb_trigger_bank_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       arm_valid = 1'b0;
    logic       arm_ready;
    logic       arm_side = 1'b0;
    logic       arm_direction = 1'b0;
    logic [7:0] arm_price = '0;
    logic [3:0] arm_id = '0;
    logic       cancel_valid = 1'b0;
    logic [3:0] cancel_id = '0;
    logic [3:0] trig_write_enable;
    logic       trig_side;
    logic       trig_direction;
    logic [7:0] trig_price;
    logic [3:0] trig_satisfied = '0;
    logic       fire_valid;
    logic       fire_ready = 1'b0;
    logic [3:0] fire_id;
    logic [1:0] fire_slot;
    logic [3:0] slots_busy;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit rn; bit av; bit [3:0] aid; bit [1:0] sd; bit [7:0] ap;
        bit cv; bit [3:0] cid; bit [3:0] sat; bit fr;
        bit ear; bit [3:0] ewe; bit [9:0] ebus; bit efv; bit [3:0] efid; bit [1:0] efs; bit [3:0] ebusy;
    } vec_t;

    vec_t tbl[$];

    trigger_bank_ctrl #(.NUM_SLOTS(4), .PRICE_WIDTH(8), .ID_WIDTH(4)) dut (
        .clock(clock), .reset(reset),
        .arm_valid(arm_valid), .arm_ready(arm_ready), .arm_side(arm_side),
        .arm_direction(arm_direction), .arm_price(arm_price), .arm_id(arm_id),
        .cancel_valid(cancel_valid), .cancel_id(cancel_id),
        .trig_write_enable(trig_write_enable), .trig_side(trig_side),
        .trig_direction(trig_direction), .trig_price(trig_price),
        .trig_satisfied(trig_satisfied),
        .fire_valid(fire_valid), .fire_ready(fire_ready), .fire_id(fire_id),
        .fire_slot(fire_slot), .slots_busy(slots_busy)
    );

    always #5 clock = ~clock;

    task automatic v(int rn, int av, int aid, int sd, int ap, int cv, int cid, int sat, int fr,
                     int ear, int ewe, int ebus, int efv, int efid, int efs, int ebusy);
        vec_t e;
        e.rn = 1'(rn); e.av = 1'(av); e.aid = 4'(aid); e.sd = 2'(sd); e.ap = 8'(ap);
        e.cv = 1'(cv); e.cid = 4'(cid); e.sat = 4'(sat); e.fr = 1'(fr);
        e.ear = 1'(ear); e.ewe = 4'(ewe); e.ebus = 10'(ebus); e.efv = 1'(efv);
        e.efid = 4'(efid); e.efs = 2'(efs); e.ebusy = 4'(ebusy);
        tbl.push_back(e);
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(int av, int aid, int sat, int fr);
        arm_valid = 1'(av);
        arm_id = 4'(aid);
        trig_satisfied = 4'(sat);
        fire_ready = 1'(fr);
        cancel_valid = 1'b0;
        step();
    endtask

    initial begin
        // single arm, satisfied at N+4, report at N+6
        v(1,1,3,2'b10,8'h64,0,0,0,0,     1,4'b0001,10'h264,0,0,0,4'b0001);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h264,0,0,0,4'b0001);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h264,0,0,0,4'b0001);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h264,0,0,0,4'b0001);
        v(1,0,0,0,0,0,0,4'b0001,0,       1,0,10'h264,0,0,0,4'b0001);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h264,1,3,0,4'b0001);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h264,0,0,0,4'b0000);
        v(0,0,0,0,0,0,0,0,0,             1,0,10'h000,0,0,0,4'b0000);
        // fill, full, round robin from 0
        v(1,1,1,2'b01,8'h10,0,0,0,0,     1,4'b0001,10'h110,0,0,0,4'b0001);
        v(1,1,2,2'b11,8'h20,0,0,0,0,     1,4'b0010,10'h320,0,0,0,4'b0011);
        v(1,1,3,2'b00,8'h30,0,0,0,0,     1,4'b0100,10'h030,0,0,0,4'b0111);
        v(1,1,4,2'b10,8'h40,0,0,0,0,     0,4'b1000,10'h240,0,0,0,4'b1111);
        v(1,1,5,2'b00,8'h50,0,0,0,0,     0,0,10'h240,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,0,             0,0,10'h240,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,4'b1111,1,       0,0,10'h240,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,1,             0,0,10'h240,1,1,0,4'b1111);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h240,1,2,1,4'b1110);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h240,1,3,2,4'b1100);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h240,1,4,3,4'b1000);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h240,0,0,0,4'b0000);
        // move rr_ptr to 2, then round robin 2,3,0,1
        v(1,1,5,2'b11,8'h55,0,0,0,0,     1,4'b0001,10'h355,0,0,0,4'b0001);
        v(1,1,6,2'b01,8'h66,0,0,0,0,     1,4'b0010,10'h166,0,0,0,4'b0011);
        v(1,1,7,2'b10,8'h77,0,0,0,0,     1,4'b0100,10'h277,0,0,0,4'b0111);
        v(1,1,8,2'b00,8'h88,0,0,0,0,     0,4'b1000,10'h088,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,0,             0,0,10'h088,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,0,             0,0,10'h088,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,4'b0010,0,       0,0,10'h088,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,0,             0,0,10'h088,1,6,1,4'b1111);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h088,0,0,0,4'b1101);
        v(1,1,10,2'b11,8'hAA,0,0,0,0,    0,4'b0010,10'h3AA,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,0,             0,0,10'h3AA,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,0,             0,0,10'h3AA,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,4'b1111,1,       0,0,10'h3AA,0,0,0,4'b1111);
        v(1,0,0,0,0,0,0,0,1,             0,0,10'h3AA,1,7,2,4'b1111);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h3AA,1,8,3,4'b1011);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h3AA,1,5,0,4'b0011);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h3AA,1,10,1,4'b0010);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h3AA,0,0,0,4'b0000);
        // backpressure: report held 5 cycles while slot 1 goes PENDING
        v(1,1,1,2'b00,8'h11,0,0,0,0,     1,4'b0001,10'h011,0,0,0,4'b0001);
        v(1,1,2,2'b11,8'h22,0,0,0,0,     1,4'b0010,10'h322,0,0,0,4'b0011);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h322,0,0,0,4'b0011);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h322,0,0,0,4'b0011);
        v(1,0,0,0,0,0,0,4'b0001,0,       1,0,10'h322,0,0,0,4'b0011);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h322,1,1,0,4'b0011);
        v(1,0,0,0,0,0,0,4'b0010,0,       1,0,10'h322,1,1,0,4'b0011);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h322,1,1,0,4'b0011);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h322,1,1,0,4'b0011);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h322,1,1,0,4'b0011);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h322,1,2,1,4'b0010);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h322,0,0,0,4'b0000);
        // cancel: SETTLE pulse ignored, ARMED cancel, presented id exempt, no-match
        v(1,1,1,2'b10,8'h01,0,0,0,0,     1,4'b0001,10'h201,0,0,0,4'b0001);
        v(1,1,2,2'b01,8'h02,0,0,0,0,     1,4'b0010,10'h102,0,0,0,4'b0011);
        v(1,1,3,2'b11,8'h03,0,0,0,0,     1,4'b0100,10'h303,0,0,0,4'b0111);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h303,0,0,0,4'b0111);
        v(1,0,0,0,0,0,0,4'b0100,0,       1,0,10'h303,0,0,0,4'b0111);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h303,0,0,0,4'b0111);
        v(1,0,0,0,0,1,2,0,0,             1,0,10'h303,0,0,0,4'b0101);
        v(1,0,0,0,0,0,0,4'b0011,0,       1,0,10'h303,0,0,0,4'b0101);
        v(1,0,0,0,0,0,0,0,0,             1,0,10'h303,1,1,0,4'b0101);
        v(1,0,0,0,0,1,1,0,0,             1,0,10'h303,1,1,0,4'b0101);
        v(1,0,0,0,0,0,0,0,1,             1,0,10'h303,0,0,0,4'b0100);
        v(1,0,0,0,0,1,7,0,0,             1,0,10'h303,0,0,0,4'b0100);
        v(1,0,0,0,0,1,3,0,0,             1,0,10'h303,0,0,0,4'b0000);

        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        chk("reset", {arm_ready, trig_write_enable, trig_side, trig_direction, trig_price,
                      fire_valid, fire_id, fire_slot, slots_busy}, 64'h2000000);

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t e;
            logic fmask;
            e = tbl[i];
            reset = e.rn;
            arm_valid = e.av;
            arm_id = e.aid;
            {arm_side, arm_direction} = e.sd;
            arm_price = e.ap;
            cancel_valid = e.cv;
            cancel_id = e.cid;
            trig_satisfied = e.sat;
            fire_ready = e.fr;
            step();
            fmask = e.efv || !e.rn;
            chk($sformatf("vec%0d", i),
                {arm_ready, trig_write_enable, trig_side, trig_direction, trig_price, fire_valid,
                 fmask ? fire_id : 4'h0, fmask ? fire_slot : 2'h0, slots_busy},
                {e.ear, e.ewe, e.ebus, e.efv, e.efid, e.efs, e.ebusy});
        end

        reset = 1'b1;
        drive(1, 1, 0, 0);
        drive(1, 2, 0, 0);
        drive(1, 3, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 4'b0111, 0);
        drive(1, 4, 0, 0);
        chk("async_pre", {fire_valid, trig_write_enable, slots_busy}, {1'b1, 4'b1000, 4'b1111});
        arm_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("async_fire_valid", 64'(fire_valid), 64'h0);
        chk("async_write_enable", 64'(trig_write_enable), 64'h0);
        chk("async_slots_busy", 64'(slots_busy), 64'h0);
        step();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1);
            chk($sformatf("post_reset%0d", k), {fire_valid, slots_busy}, 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
